// File: rtl/ptg_pkg.sv
// Shared definitions for the pulse train generator.
//  - State encoding for the IDLE / ARMED / RUN controller.
//  - Mode constants decoding mode_i.
package ptg_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] ARMED_ENC = 2'd1;
  localparam logic [1:0] RUN_ENC   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE_ENC,
    ST_ARMED = ARMED_ENC,
    ST_RUN   = RUN_ENC
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage : ptg_pkg

// File: rtl/pulse_window_cmp.sv
// Combinational window comparator for one pulse channel.
//  cnt_i   : current period counter value
//  start_i : window start (inclusive)
//  stop_i  : window stop (inclusive)
//  hit_o   : cnt_i lies inside the window
// A start above stop describes a window that wraps across the end of the
// period, so the test becomes a union instead of an intersection.
module pulse_window_cmp #(
  parameter int CNT_W = 8
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] start_i,
  input  logic [CNT_W-1:0] stop_i,
  output logic             hit_o
);

  logic ge_start;
  logic le_stop;

  assign ge_start = (cnt_i >= start_i);
  assign le_stop  = (cnt_i <= stop_i);
  assign hit_o    = (start_i <= stop_i) ? (ge_start & le_stop)
                                        : (ge_start | le_stop);

endmodule : pulse_window_cmp

// File: rtl/pulse_train_gen.sv
// Multi-channel programmable pulse generator.
// One shared period counter drives N_CH pulse windows. Timing inputs are
// captured into shadow registers when RUN is entered and on every wrap, so
// software may rewrite them at any time without disturbing the current period.
//  clk_i    : clock, rising edge
//  rst_i    : asynchronous reset, active-high
//  en_i     : block enable; low returns to IDLE
//  mode_i   : 0 periodic, 1 triggered one-shot
//  trig_i   : one-shot trigger, level sampled in ARMED
//  period_i : last counter value of a period
//  start_i  : per-channel window start, channel c at [c*CNT_W +: CNT_W]
//  stop_i   : per-channel window stop, same packing
//  pls_o    : registered pulse outputs
//  cnt_o    : current counter value
//  wrap_o   : registered strobe, one cycle after cnt reached the period end
//  busy_o   : high while in RUN
module pulse_train_gen
  import ptg_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int N_CH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  mode_i,
  input  logic                  trig_i,
  input  logic [CNT_W-1:0]      period_i,
  input  logic [N_CH*CNT_W-1:0] start_i,
  input  logic [N_CH*CNT_W-1:0] stop_i,
  output logic [N_CH-1:0]       pls_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic                  wrap_o,
  output logic                  busy_o
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      period_sh_q, period_sh_d;
  logic [N_CH*CNT_W-1:0] start_sh_q, start_sh_d;
  logic [N_CH*CNT_W-1:0] stop_sh_q, stop_sh_d;
  logic [N_CH-1:0]       pls_q, pls_d;
  logic                  wrap_q, wrap_d;

  logic                  busy;
  logic                  at_end;
  logic                  load_sh;
  logic [N_CH-1:0]       hit;

  assign busy   = (state_q == ST_RUN);
  assign at_end = (cnt_q == period_sh_q);

  for (genvar c = 0; c < N_CH; c++) begin : g_win
    pulse_window_cmp #(
      .CNT_W(CNT_W)
    ) u_win (
      .cnt_i  (cnt_q),
      .start_i(start_sh_q[c*CNT_W +: CNT_W]),
      .stop_i (stop_sh_q[c*CNT_W +: CNT_W]),
      .hit_o  (hit[c])
    );
  end

  // Controller and counter. en_i low wins over everything else; the counter
  // is held at zero whenever it is not advancing inside RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    load_sh = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          if (mode_i == MODE_ONESHOT) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_RUN;
            load_sh = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (trig_i) begin
          state_d = ST_RUN;
          load_sh = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (at_end) begin
          load_sh = 1'b1;
          if (mode_i == MODE_ONESHOT) begin
            state_d = ST_ARMED;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    period_sh_d = load_sh ? period_i : period_sh_q;
    start_sh_d  = load_sh ? start_i  : start_sh_q;
    stop_sh_d   = load_sh ? stop_i   : stop_sh_q;
  end

  // Outputs are registered from the current count, giving one cycle of
  // latency and a clean zero on the cycle after RUN is left.
  always_comb begin
    pls_d  = busy ? hit : '0;
    wrap_d = busy & at_end;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      period_sh_q <= '0;
      start_sh_q  <= '0;
      stop_sh_q   <= '0;
      pls_q       <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_sh_q <= period_sh_d;
      start_sh_q  <= start_sh_d;
      stop_sh_q   <= stop_sh_d;
      pls_q       <= pls_d;
      wrap_q      <= wrap_d;
    end
  end

  assign pls_o  = pls_q;
  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;
  assign busy_o = busy;

endmodule : pulse_train_gen

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: a cycle table for periodic operation
// followed by hand-written sequences for the multi-cycle corner cases.
module tb_pulse_train_gen;

  localparam int CNT_W = 8;
  localparam int N_CH  = 4;
  localparam int NVEC  = 21;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic                  mode;
  logic                  trig;
  logic [CNT_W-1:0]      period;
  logic [N_CH*CNT_W-1:0] start;
  logic [N_CH*CNT_W-1:0] stop;
  logic [N_CH-1:0]       pls;
  logic [CNT_W-1:0]      cnt;
  logic                  wrap;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic       mode;
    logic       trig;
    logic [7:0] period;
    logic [7:0] exp_cnt;
    logic       exp_busy;
    logic [3:0] exp_pls;
    logic       exp_wrap;
  } vec_t;

  vec_t tbl [NVEC];

  pulse_train_gen #(
    .CNT_W(CNT_W),
    .N_CH (N_CH)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .mode_i  (mode),
    .trig_i  (trig),
    .period_i(period),
    .start_i (start),
    .stop_i  (stop),
    .pls_o   (pls),
    .cnt_o   (cnt),
    .wrap_o  (wrap),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    en   = 1'b0;
    mode = 1'b0;
    trig = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
  endtask

  function automatic vec_t mk(input logic m, input logic t, input logic [7:0] c,
                              input logic [3:0] p, input logic w);
    vec_t v;
    v.en       = 1'b1;
    v.mode     = m;
    v.trig     = t;
    v.period   = 8'd9;
    v.exp_cnt  = c;
    v.exp_busy = 1'b1;
    v.exp_pls  = p;
    v.exp_wrap = w;
    return v;
  endfunction

  initial begin
    int n;
    int nb;
    bit done;

    // ch0 2..4, ch1 8..1 (wrapping), ch2 5..7, ch3 beyond the period
    tbl[0]  = mk(0, 0, 8'd0, 4'b0000, 0);
    tbl[1]  = mk(0, 0, 8'd1, 4'b0010, 0);
    tbl[2]  = mk(0, 0, 8'd2, 4'b0010, 0);
    tbl[3]  = mk(0, 0, 8'd3, 4'b0001, 0);
    tbl[4]  = mk(0, 0, 8'd4, 4'b0001, 0);
    tbl[5]  = mk(1, 0, 8'd5, 4'b0001, 0);
    tbl[6]  = mk(0, 0, 8'd6, 4'b0100, 0);
    tbl[7]  = mk(0, 1, 8'd7, 4'b0100, 0);
    tbl[8]  = mk(0, 0, 8'd8, 4'b0100, 0);
    tbl[9]  = mk(0, 0, 8'd9, 4'b0010, 0);
    tbl[10] = mk(0, 0, 8'd0, 4'b0010, 1);
    tbl[11] = mk(0, 0, 8'd1, 4'b0010, 0);
    tbl[12] = mk(0, 0, 8'd2, 4'b0010, 0);
    tbl[13] = mk(0, 0, 8'd3, 4'b0001, 0);
    tbl[14] = mk(0, 0, 8'd4, 4'b0001, 0);
    tbl[15] = mk(0, 0, 8'd5, 4'b0001, 0);
    tbl[16] = mk(0, 0, 8'd6, 4'b0100, 0);
    tbl[17] = mk(0, 0, 8'd7, 4'b0100, 0);
    tbl[18] = mk(0, 0, 8'd8, 4'b0100, 0);
    tbl[19] = mk(0, 0, 8'd9, 4'b0010, 0);
    tbl[20] = mk(0, 0, 8'd0, 4'b0010, 1);

    rst    = 1'b0;
    en     = 1'b0;
    mode   = 1'b0;
    trig   = 1'b0;
    period = 8'd9;
    start  = {8'd200, 8'd5, 8'd8, 8'd2};
    stop   = {8'd210, 8'd7, 8'd1, 8'd4};

    // Reset state
    #2 rst = 1'b1;
    #2;
    chk("reset_cnt",  32'(cnt),  32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pls",  32'(pls),  32'd0);
    chk("reset_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Periodic operation, two windows plus wrap-across window
    for (int i = 0; i < NVEC; i++) begin
      en     = tbl[i].en;
      mode   = tbl[i].mode;
      trig   = tbl[i].trig;
      period = tbl[i].period;
      step();
      chk($sformatf("row%0d_cnt", i),  32'(cnt),  32'(tbl[i].exp_cnt));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
      chk($sformatf("row%0d_pls", i),  32'(pls),  32'(tbl[i].exp_pls));
      chk($sformatf("row%0d_wrap", i), 32'(wrap), 32'(tbl[i].exp_wrap));
    end

    // Period change mid-period takes effect only at the next period
    n = 0;
    done = 1'b0;
    while (!done) begin
      step();
      n++;
      if (cnt == 8'd5) period = 8'd3;
      if (wrap || n >= 40) done = 1'b1;
    end
    chk("wrap_spacing_1", 32'(n), 32'd10);
    n = 0;
    done = 1'b0;
    while (!done) begin
      step();
      n++;
      if (wrap || n >= 40) done = 1'b1;
    end
    chk("wrap_spacing_2", 32'(n), 32'd4);

    // One-shot: single trigger, second trigger during RUN ignored
    do_reset();
    period = 8'd5;
    mode   = 1'b1;
    en     = 1'b1;
    step();
    chk("armed_busy", 32'(busy), 32'd0);
    chk("armed_cnt",  32'(cnt),  32'd0);
    step();
    chk("armed_hold", 32'(busy), 32'd0);
    trig = 1'b1;
    step();
    chk("trig_run", 32'(busy), 32'd1);
    trig = 1'b0;
    nb = 1;
    n  = 0;
    done = 1'b0;
    while (!done) begin
      step();
      n++;
      if (busy) begin
        nb++;
        trig = (nb == 3);
      end else begin
        done = 1'b1;
      end
      if (n >= 30) done = 1'b1;
    end
    trig = 1'b0;
    chk("oneshot_busy_len", 32'(nb), 32'd6);
    chk("oneshot_end_wrap", 32'(wrap), 32'd1);
    chk("oneshot_end_cnt",  32'(cnt),  32'd0);
    step();
    step();
    step();
    chk("no_retrigger", 32'(busy), 32'd0);

    // Trigger held high: back-to-back periods with one ARMED gap cycle
    trig = 1'b1;
    step();
    chk("held_run", 32'(busy), 32'd1);
    nb = 1;
    n  = 0;
    done = 1'b0;
    while (!done) begin
      step();
      n++;
      if (busy) nb++;
      else done = 1'b1;
      if (n >= 30) done = 1'b1;
    end
    chk("held_busy_len", 32'(nb), 32'd6);
    step();
    chk("held_gap_rerun", 32'(busy), 32'd1);
    trig = 1'b0;

    // en_i drop mid-pulse
    do_reset();
    period = 8'd9;
    start  = {8'd200, 8'd5, 8'd8, 8'd2};
    stop   = {8'd210, 8'd7, 8'd1, 8'd4};
    en     = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("pre_drop_pls", 32'(pls), 32'h1);
    en = 1'b0;
    step();
    chk("drop_cnt",  32'(cnt),  32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_pls_lag", 32'(pls), 32'h1);
    step();
    chk("drop_pls_off", 32'(pls), 32'h0);

    // Asynchronous reset mid-pulse
    en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_pls", 32'(pls), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("arst_cnt",  32'(cnt),  32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pls",  32'(pls),  32'd0);
    chk("arst_wrap", 32'(wrap), 32'd0);
    #1 rst = 1'b0;

    // Period 0: wrap every cycle, s=0 and wrapping windows stay high
    do_reset();
    period = 8'd0;
    start  = {8'd200, 8'd5, 8'd8, 8'd0};
    stop   = {8'd210, 8'd7, 8'd1, 8'd0};
    en     = 1'b1;
    step();
    chk("p0_first_busy", 32'(busy), 32'd1);
    chk("p0_first_pls",  32'(pls),  32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("p0_cnt%0d", i),  32'(cnt),  32'd0);
      chk($sformatf("p0_wrap%0d", i), 32'(wrap), 32'd1);
      chk($sformatf("p0_pls%0d", i),  32'(pls),  32'b0011);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pulse_train_gen
